// File: rtl/fp_pkg.sv
// Shared floating-point helpers for the PE datapath arithmetic blocks.
// Holds the operand class enum, the exception flag struct and width-generic
// helper functions: exponent bias, field extraction, classification and the
// canonical quiet NaN. All helpers work on 64-bit containers, so a caller
// zero-extends its operand and truncates the result to its own widths.
package fp_pkg;

    typedef enum logic [1:0] {
        FP_ZERO,
        FP_NORM,
        FP_INF,
        FP_NAN
    } fp_class_e;

    typedef struct packed {
        logic invalid;
        logic overflow;
        logic underflow;
        logic inexact;
    } fp_flags_t;

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] fp_exp_field(input logic [63:0] x, input int exp_w,
                                                 input int man_w);
        return (x >> man_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction

    function automatic logic [63:0] fp_man_field(input logic [63:0] x, input int man_w);
        return x & ((64'd1 << man_w) - 64'd1);
    endfunction

    // Sign 0, exponent all ones, only the mantissa MSB set.
    function automatic logic [63:0] fp_qnan(input int exp_w, input int man_w);
        return (((64'd1 << exp_w) - 64'd1) << man_w) | (64'd1 << (man_w - 1));
    endfunction

    // Subnormals (exp == 0, man != 0) classify as zero: denormals are flushed.
    function automatic fp_class_e fp_classify(input logic [63:0] e, input logic [63:0] m,
                                              input int exp_w);
        if (e == 64'd0) begin
            return FP_ZERO;
        end
        if (e == ((64'd1 << exp_w) - 64'd1)) begin
            return (m == 64'd0) ? FP_INF : FP_NAN;
        end
        return FP_NORM;
    endfunction

endpackage

// File: rtl/fp_round_norm.sv
// Combinational normalize / round-to-nearest-even / pack for finite results.
// Ports:
//   sign    result sign
//   exp_in  biased exponent of the product, signed, before normalization
//   prod    unsigned (MAN_W+1)x(MAN_W+1) mantissa product, leading one in
//           one of the two top bits
//   result  packed {sign, exp, man}
//   flags   overflow / underflow / inexact (invalid is never raised here)
module fp_round_norm
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    localparam int DATA_W = 1 + EXP_W + MAN_W,
    localparam int XW = EXP_W + 2,
    localparam int PW = 2 * MAN_W + 2
) (
    input  logic                 sign,
    input  logic signed [XW-1:0] exp_in,
    input  logic [PW-1:0]        prod,
    output logic [DATA_W-1:0]    result,
    output fp_flags_t            flags
);

    localparam logic signed [XW-1:0] EXP_ONE = 1;
    localparam logic signed [XW-1:0] EXP_MAX = XW'((1 << EXP_W) - 1);

    logic [MAN_W-1:0]      man_keep;
    logic                  guard;
    logic                  sticky;
    logic                  round_up;
    logic [MAN_W:0]        man_rnd;
    logic signed [XW-1:0]  exp_norm;
    logic signed [XW-1:0]  exp_rnd;

    always_comb begin
        // A product in [2,4) carries its leading one in the top bit.
        if (prod[PW-1]) begin
            man_keep = prod[2*MAN_W -: MAN_W];
            guard    = prod[MAN_W];
            sticky   = |prod[MAN_W-1:0];
            exp_norm = exp_in + EXP_ONE;
        end else begin
            man_keep = prod[2*MAN_W-1 -: MAN_W];
            guard    = prod[MAN_W-1];
            sticky   = |prod[MAN_W-2:0];
            exp_norm = exp_in;
        end

        round_up = guard && (sticky || man_keep[0]);
        man_rnd  = {1'b0, man_keep} + (MAN_W+1)'(round_up);
        // Carry out of 1.11..1 leaves a zero mantissa one binade up.
        exp_rnd  = exp_norm + $signed({{(XW-1){1'b0}}, man_rnd[MAN_W]});

        flags = '0;
        if (exp_rnd < EXP_ONE) begin
            result          = {sign, {(DATA_W-1){1'b0}}};
            flags.underflow = 1'b1;
            flags.inexact   = 1'b1;
        end else if (exp_rnd >= EXP_MAX) begin
            result         = {sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
            flags.overflow = 1'b1;
            flags.inexact  = 1'b1;
        end else begin
            result        = {sign, exp_rnd[EXP_W-1:0], man_rnd[MAN_W-1:0]};
            flags.inexact = guard || sticky;
        end
    end

endmodule

// File: rtl/fp_mult_pipe.sv
// Pipelined floating-point multiplier with valid/ready handshakes.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   operand handshake for A, B, in_tag
//   A, B                operands {sign, exp, man}
//   in_tag              sideband tag returned with the result
//   out_valid/out_ready result handshake
//   O                   product
//   out_tag             tag of the operation that produced O
//   out_flags           {invalid, overflow, underflow, inexact}
// Three registered compute stages (unpack, multiply, round) feed an output
// register; a single global enable stalls the whole chain when the output
// is held, so four operations can be in flight under backpressure.
module fp_mult_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 7,
    parameter int TAG_W = 4,
    localparam int DATA_W = 1 + EXP_W + MAN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] A,
    input  logic [DATA_W-1:0] B,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] O,
    output logic [TAG_W-1:0]  out_tag,
    output logic [3:0]        out_flags
);

    localparam int XW = EXP_W + 2;
    localparam int PW = 2 * MAN_W + 2;
    localparam logic signed [XW-1:0] BIAS = XW'(fp_bias(EXP_W));
    localparam logic [DATA_W-1:0]    QNAN = DATA_W'(fp_qnan(EXP_W, MAN_W));

    logic en;
    assign en       = !(out_valid && !out_ready);
    assign in_ready = en;

    // ---- S1: unpack and classify ----
    logic [EXP_W-1:0] exp_a, exp_b;
    logic [MAN_W-1:0] man_a, man_b;
    fp_class_e        cls_a, cls_b;
    logic             snan_in;

    assign exp_a   = EXP_W'(fp_exp_field(64'(A), EXP_W, MAN_W));
    assign exp_b   = EXP_W'(fp_exp_field(64'(B), EXP_W, MAN_W));
    assign man_a   = MAN_W'(fp_man_field(64'(A), MAN_W));
    assign man_b   = MAN_W'(fp_man_field(64'(B), MAN_W));
    assign cls_a   = fp_classify(64'(exp_a), 64'(man_a), EXP_W);
    assign cls_b   = fp_classify(64'(exp_b), 64'(man_b), EXP_W);
    assign snan_in = ((cls_a == FP_NAN) && !man_a[MAN_W-1]) ||
                     ((cls_b == FP_NAN) && !man_b[MAN_W-1]);

    logic             vld_p0, sign_p0, snan_p0;
    fp_class_e        cls_a_p0, cls_b_p0;
    logic [EXP_W-1:0] exp_a_p0, exp_b_p0;
    logic [MAN_W-1:0] man_a_p0, man_b_p0;
    logic [TAG_W-1:0] tag_p0;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0 <= 1'b0;
        end else if (en) begin
            vld_p0 <= in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sign_p0  <= A[DATA_W-1] ^ B[DATA_W-1];
            snan_p0  <= snan_in;
            cls_a_p0 <= cls_a;
            cls_b_p0 <= cls_b;
            exp_a_p0 <= exp_a;
            exp_b_p0 <= exp_b;
            man_a_p0 <= man_a;
            man_b_p0 <= man_b;
            tag_p0   <= in_tag;
        end
    end

    // ---- S2: mantissa product, exponent sum, special-case result ----
    logic [PW-1:0]        prod_s2;
    logic signed [XW-1:0] exp_s2;
    logic                 spec_s2;
    logic [DATA_W-1:0]    spec_val_s2;
    fp_flags_t            spec_flags_s2;

    assign prod_s2 = PW'({1'b1, man_a_p0}) * PW'({1'b1, man_b_p0});
    assign exp_s2  = $signed(XW'(exp_a_p0)) + $signed(XW'(exp_b_p0)) - BIAS;

    always_comb begin
        spec_s2       = 1'b1;
        spec_val_s2   = QNAN;
        spec_flags_s2 = '0;
        if (cls_a_p0 == FP_NAN || cls_b_p0 == FP_NAN) begin
            spec_flags_s2.invalid = snan_p0;
        end else if ((cls_a_p0 == FP_INF && cls_b_p0 == FP_ZERO) ||
                     (cls_a_p0 == FP_ZERO && cls_b_p0 == FP_INF)) begin
            spec_flags_s2.invalid = 1'b1;
        end else if (cls_a_p0 == FP_INF || cls_b_p0 == FP_INF) begin
            spec_val_s2 = {sign_p0, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
        end else if (cls_a_p0 == FP_ZERO || cls_b_p0 == FP_ZERO) begin
            spec_val_s2 = {sign_p0, {(DATA_W-1){1'b0}}};
        end else begin
            spec_s2 = 1'b0;
        end
    end

    logic                 vld_p1, sign_p1, spec_p1;
    logic [PW-1:0]        prod_p1;
    logic signed [XW-1:0] exp_p1;
    logic [DATA_W-1:0]    spec_val_p1;
    fp_flags_t            spec_flags_p1;
    logic [TAG_W-1:0]     tag_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1 <= 1'b0;
        end else if (en) begin
            vld_p1 <= vld_p0;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            sign_p1       <= sign_p0;
            spec_p1       <= spec_s2;
            prod_p1       <= prod_s2;
            exp_p1        <= exp_s2;
            spec_val_p1   <= spec_val_s2;
            spec_flags_p1 <= spec_flags_s2;
            tag_p1        <= tag_p0;
        end
    end

    // ---- S3: normalize, round, pack ----
    logic [DATA_W-1:0] rn_result;
    fp_flags_t         rn_flags;

    fp_round_norm #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_round_norm (
        .sign   (sign_p1),
        .exp_in (exp_p1),
        .prod   (prod_p1),
        .result (rn_result),
        .flags  (rn_flags)
    );

    logic              vld_p2;
    logic [DATA_W-1:0] res_p2;
    fp_flags_t         flags_p2;
    logic [TAG_W-1:0]  tag_p2;

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p2 <= 1'b0;
        end else if (en) begin
            vld_p2 <= vld_p1;
        end
    end

    always_ff @(posedge clk) begin
        if (en) begin
            res_p2   <= spec_p1 ? spec_val_p1 : rn_result;
            flags_p2 <= spec_p1 ? spec_flags_p1 : rn_flags;
            tag_p2   <= tag_p1;
        end
    end

    // ---- Output register ----
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            O         <= '0;
            out_tag   <= '0;
            out_flags <= '0;
        end else if (en) begin
            out_valid <= vld_p2;
            if (vld_p2) begin
                O         <= res_p2;
                out_tag   <= tag_p2;
                out_flags <= flags_p2;
            end
        end
    end

endmodule

// File: tb/tb_fp_mult_pipe.sv
// Scoreboard bench for fp_mult_pipe: a bfloat16 instance with handshakes and
// backpressure, plus an fp16 instance for the parameter sweep.
module tb_fp_mult_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        rst;
    logic        in_valid, in_ready, out_valid, out_ready;
    logic [15:0] A, B, O;
    logic [3:0]  in_tag, out_tag, out_flags;

    logic        h_in_valid, h_in_ready, h_out_valid;
    logic [15:0] h_A, h_B, h_O;
    logic [3:0]  h_in_tag, h_out_tag, h_out_flags;

    fp_mult_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .in_tag(in_tag), .out_valid(out_valid), .out_ready(out_ready),
        .O(O), .out_tag(out_tag), .out_flags(out_flags)
    );

    fp_mult_pipe #(.EXP_W(5), .MAN_W(10)) dut_h (
        .clk(clk), .rst(rst), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .A(h_A), .B(h_B), .in_tag(h_in_tag), .out_valid(h_out_valid), .out_ready(1'b1),
        .O(h_O), .out_tag(h_out_tag), .out_flags(h_out_flags)
    );

    typedef struct packed {
        logic [15:0] o;
        logic [3:0]  tag;
        logic [3:0]  flags;
        logic        lat_chk;
        logic [31:0] t;
    } exp_t;

    exp_t sb[$];
    exp_t sbh[$];
    exp_t mon_e, mon_he;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitors: pop on every output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'(O), 32'hFFFF_FFFF);
            end else begin
                mon_e = sb.pop_front();
                check("O", 32'(O), 32'(mon_e.o));
                check("out_tag", 32'(out_tag), 32'(mon_e.tag));
                check("out_flags", 32'(out_flags), 32'(mon_e.flags));
                if (mon_e.lat_chk) check("latency", 32'(cyc) - mon_e.t, 32'd3);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && h_out_valid) begin
            if (sbh.size() == 0) begin
                check("h_unexpected_output", 32'(h_O), 32'hFFFF_FFFF);
            end else begin
                mon_he = sbh.pop_front();
                check("h_O", 32'(h_O), 32'(mon_he.o));
                check("h_out_tag", 32'(h_out_tag), 32'(mon_he.tag));
                check("h_out_flags", 32'(h_out_flags), 32'(mon_he.flags));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                        input logic [15:0] eo, input logic [3:0] ef, input logic lat);
        exp_t e;
        bit   acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        A = a; B = b; in_tag = tag; in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (in_ready) begin
                acc       = 1'b1;
                e.o       = eo;
                e.tag     = tag;
                e.flags   = ef;
                e.lat_chk = lat;
                e.t       = 32'(cyc + 1);
                sb.push_back(e);
            end
            @(posedge clk); #1;
            n++;
        end
        in_valid = 1'b0;
        if (!acc) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_h(input logic [15:0] a, input logic [15:0] b, input logic [3:0] tag,
                          input logic [15:0] eo, input logic [3:0] ef);
        exp_t e;
        bit   acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        h_A = a; h_B = b; h_in_tag = tag; h_in_valid = 1'b1;
        while (!acc && n < 50) begin
            @(negedge clk);
            if (h_in_ready) begin
                acc       = 1'b1;
                e.o       = eo;
                e.tag     = tag;
                e.flags   = ef;
                e.lat_chk = 1'b0;
                e.t       = '0;
                sbh.push_back(e);
            end
            @(posedge clk); #1;
            n++;
        end
        h_in_valid = 1'b0;
        if (!acc) check("h_send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sb.size() != 0 || sbh.size() != 0) && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain", 32'(sb.size() + sbh.size()), 32'd0);
    endtask

    // Backpressure vectors: the stream plus one rounding case.
    logic [15:0] bp_a [5] = '{16'h4040, 16'h4100, 16'h4480, 16'h3FA0, 16'h3F81};
    logic [15:0] bp_b [5] = '{16'h3F80, 16'h449B, 16'h4600, 16'h4020, 16'h3F81};
    logic [15:0] bp_o [5] = '{16'h4040, 16'h461B, 16'h4B00, 16'h4048, 16'h3F82};
    logic [3:0]  bp_f [5] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h1};

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int   nacc;
        int   seen;
        exp_t e;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; A = '0; B = '0; in_tag = '0;
        h_in_valid = 1'b0; h_A = '0; h_B = '0; h_in_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_O", 32'(O), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_flags", 32'(out_flags), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_h_out_valid", 32'(h_out_valid), 32'd0);
        @(posedge clk); #1;

        // Back-to-back stream.
        send(16'h4040, 16'h3F80, 4'h1, 16'h4040, 4'h0, 1'b1);
        send(16'h4100, 16'h449B, 4'h2, 16'h461B, 4'h0, 1'b1);
        send(16'h4480, 16'h4600, 4'h3, 16'h4B00, 4'h0, 1'b1);
        send(16'h3FA0, 16'h4020, 4'h4, 16'h4048, 4'h0, 1'b1);
        // Rounding and specials (flags = {invalid, overflow, underflow, inexact}).
        send(16'h3F81, 16'h3F81, 4'h5, 16'h3F82, 4'b0001, 1'b1);
        send(16'h3FC0, 16'h3F81, 4'h6, 16'h3FC2, 4'b0001, 1'b1);
        send(16'h7F00, 16'h4000, 4'h7, 16'h7F80, 4'b0101, 1'b1);
        send(16'h0080, 16'h3F00, 4'h8, 16'h0000, 4'b0011, 1'b1);
        send(16'h7F80, 16'h0000, 4'h9, 16'h7FC0, 4'b1000, 1'b1);
        send(16'hFF80, 16'h4000, 4'hA, 16'hFF80, 4'b0000, 1'b1);
        send(16'h7F81, 16'h3F80, 4'hB, 16'h7FC0, 4'b1000, 1'b1);
        send(16'h7FC1, 16'h4000, 4'hC, 16'h7FC0, 4'b0000, 1'b1);
        send(16'h8000, 16'h3F80, 4'hD, 16'h8000, 4'b0000, 1'b1);
        send(16'h0001, 16'h4000, 4'hE, 16'h0000, 4'b0000, 1'b1);
        drain();

        // Backpressure: five offered, four accepted while out_ready is low.
        out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 8; c++) begin
            if (nacc < 5) begin
                A = bp_a[nacc]; B = bp_b[nacc]; in_tag = 4'(8 + nacc); in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (in_valid && in_ready) begin
                e.o = bp_o[nacc]; e.tag = 4'(8 + nacc); e.flags = bp_f[nacc];
                e.lat_chk = 1'b0; e.t = '0;
                sb.push_back(e);
                nacc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        check("bp_accepted", 32'(nacc), 32'd4);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            if (sb.size() != 0) check("bp_hold_O", 32'(O), 32'(sb[0].o));
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(bp_a[4], bp_b[4], 4'hC, bp_o[4], bp_f[4], 1'b0);
        drain();

        // Reset with three operations in flight.
        send(16'h4040, 16'h3F80, 4'h1, 16'h4040, 4'h0, 1'b1);
        send(16'h4100, 16'h449B, 4'h2, 16'h461B, 4'h0, 1'b1);
        send(16'h4480, 16'h4600, 4'h3, 16'h4B00, 4'h0, 1'b1);
        rst = 1'b1;
        sb.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_O", 32'(O), 32'd0);
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("midrst_no_stale", 32'(seen), 32'd0);
        @(posedge clk); #1;

        // fp16 parameter sweep.
        send_h(16'h3C00, 16'h4000, 4'h1, 16'h4000, 4'b0000);
        send_h(16'h7BFF, 16'h4000, 4'h2, 16'h7C00, 4'b0101);
        send_h(16'h3C01, 16'h3C01, 4'h3, 16'h3C02, 4'b0001);
        drain();

        check("sb_empty", 32'(sb.size() + sbh.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
